// File: rtl/mult_16x16_seq_ctrl.sv
// Sequential 16x16 multiplier: one shared 8x8 multiplier accumulates four partial products.
// Define MULT_SEQ_SIGNED_EN to add the in_signed port for two's-complement operands.
module mult_16x16_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
`ifdef MULT_SEQ_SIGNED_EN
    ,
    input  logic        in_signed
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic        neg_q, neg_d;

    logic        accept;
    logic [15:0] op_a_in, op_b_in;
    logic        neg_in;
    logic [7:0]  mul_x, mul_y;
    logic [15:0] mul_p;
    logic [31:0] term;
    logic [31:0] sum;

    assign accept = in_valid & in_ready;

`ifdef MULT_SEQ_SIGNED_EN
    // Store magnitudes; 0x8000 negates to itself, which is the correct unsigned magnitude.
    logic sign_a, sign_b;
    assign sign_a  = in_signed & in_a[15];
    assign sign_b  = in_signed & in_b[15];
    assign op_a_in = sign_a ? (~in_a + 16'd1) : in_a;
    assign op_b_in = sign_b ? (~in_b + 16'd1) : in_b;
    assign neg_in  = sign_a ^ sign_b;
`else
    assign op_a_in = in_a;
    assign op_b_in = in_b;
    assign neg_in  = 1'b0;
`endif

    assign mul_x = (state_q == P1 || state_q == P3) ? a_q[15:8] : a_q[7:0];
    assign mul_y = (state_q == P2 || state_q == P3) ? b_q[15:8] : b_q[7:0];
    assign mul_p = mul_x * mul_y;

    always_comb begin
        term = 32'd0;
        case (state_q)
            P0:      term = {16'd0, mul_p};
            P1, P2:  term = {8'd0, mul_p, 8'd0};
            P3:      term = {mul_p, 16'd0};
            default: term = 32'd0;
        endcase
    end

    assign sum = acc_q + term;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = op_a_in;
                    b_d     = op_b_in;
                    neg_d   = neg_in;
                    acc_d   = 32'd0;
                    state_d = P0;
                end
            end
            P0: begin
                acc_d   = sum;
                state_d = P1;
            end
            P1: begin
                acc_d   = sum;
                state_d = P2;
            end
            P2: begin
                acc_d   = sum;
                state_d = P3;
            end
            P3: begin
                // Sign fix-up folded into the last step keeps latency identical in both builds.
                acc_d   = neg_q ? (~sum + 32'd1) : sum;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            acc_q   <= 32'd0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_p     = acc_q;

endmodule

// File: tb/tb_mult_16x16_seq_ctrl.sv
// Scoreboard bench for mult_16x16_seq_ctrl; signed vectors run when MULT_SEQ_SIGNED_EN is defined.
module tb_mult_16x16_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        busy;
`ifdef MULT_SEQ_SIGNED_EN
    logic        in_signed;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] sb[$];

    mult_16x16_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
`ifdef MULT_SEQ_SIGNED_EN
        ,
        .in_signed (in_signed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes on the posedge following a negedge with valid & ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", out_p, 32'hDEADBEEF);
                end else begin
                    chk("product", out_p, sb.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at accept edge+1 with in_valid dropped.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                         output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) chk("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        sb.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges with the accept edge as edge 1, until out_valid is seen.
    task automatic wait_valid(output int edges, output logic busy_ok);
        edges = 1;
        busy_ok = busy;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            busy_ok = busy_ok & busy;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int          w;
        int          edges;
        logic        bok;
        int          acc_cyc[3];
        logic [15:0] va[3];
        logic [15:0] vb[3];
        logic [31:0] vp[3];

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          edges;
        logic        bok;
        int          acc_cyc[3];
        logic [15:0] va[3];
        logic [15:0] vb[3];
        logic [31:0] vp[3];

        va = '{16'h00FF, 16'h8000, 16'h1111};
        vb = '{16'h0101, 16'h0002, 16'h0003};
        vp = '{32'h0000FFFF, 32'h00010000, 32'h00003333};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 16'h0;
        in_b = 16'h0;
        out_ready = 1'b1;
`ifdef MULT_SEQ_SIGNED_EN
        in_signed = 1'b0;
`endif
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_p", out_p, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(16'h1234, 16'h5678, 32'h06260060, w);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_valid(edges, bok);
        chk("latency_edge", 32'(edges), 32'd5);
        chk("busy_until_done", 32'(bok), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, w);
        wait_valid(edges, bok);
        @(posedge clk);
        #1;
        issue(16'h0000, 16'hFFFF, 32'h00000000, w);
        wait_valid(edges, bok);
        @(posedge clk);
        #1;

        // Stall in DONE while scrambling ignored inputs.
        out_ready = 1'b0;
        issue(16'hABCD, 16'h0010, 32'h000ABCD0, w);
        wait_valid(edges, bok);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            @(posedge clk);
            #1;
            chk("hold_out_p", out_p, 32'h000ABCD0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // Reset in P2 aborts the pending product.
        issue(16'd7, 16'd9, 32'd63, w);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_p", out_p, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(16'd3, 16'd5, 32'h0000000F, w);
        chk("first_edge_accept_wait", 32'(w), 32'd0);
        chk("first_edge_accept_busy", 32'(busy), 32'd1);
        wait_valid(edges, bok);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = va[i];
            in_b = vb[i];
            w = 0;
            while (!in_ready && w < 20) begin
                @(posedge clk);
                #1;
                w++;
            end
            @(posedge clk);
            sb.push_back(vp[i]);
            #1;
            acc_cyc[i] = cyc;
        end
        in_valid = 1'b0;
        chk("b2b_gap_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        chk("b2b_gap_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        wait_valid(edges, bok);
        @(posedge clk);
        #1;

`ifdef MULT_SEQ_SIGNED_EN
        in_signed = 1'b1;
        issue(16'hFFFE, 16'h0003, 32'hFFFFFFFA, w);
        wait_valid(edges, bok);
        chk("signed_latency_edge", 32'(edges), 32'd5);
        @(posedge clk);
        #1;
        issue(16'h8000, 16'h8000, 32'h40000000, w);
        wait_valid(edges, bok);
        @(posedge clk);
        #1;
        in_signed = 1'b0;
        issue(16'hFFFE, 16'h0003, 32'h0002FFFA, w);
        wait_valid(edges, bok);
        @(posedge clk);
        #1;
`endif

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_16x16_seq_ctrl.md
MULT_16X16_SEQ_CTRL -- requirements
Module: mult_16x16_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 The ports SHALL be:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  16  multiplicand.
- in_b  input  16  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_p  output  32  product.
- busy  output  1  high in any state other than IDLE.
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 The block SHALL compute in_a*in_b using exactly one internal 8x8 unsigned combinational multiplier instance (8b x 8b -> 16b), time-shared over four cycles.
REQ-005 The FSM states SHALL be IDLE, P0, P1, P2, P3 and DONE.
REQ-006 in_ready SHALL equal 1 only in IDLE.
REQ-007 The accept transfer is in_valid & in_ready; on accept, in_a and in_b SHALL be captured, the 32-bit accumulator cleared, and the next state set to P0.
REQ-008 P0 SHALL add a[7:0]*b[7:0] to the accumulator; then P1 adds (a[15:8]*b[7:0])<<8, P2 adds (a[7:0]*b[15:8])<<8, and P3 adds (a[15:8]*b[15:8])<<16.
REQ-009 Each P state SHALL last exactly one cycle; P3 SHALL go to DONE.
REQ-010 Accumulation SHALL be 32-bit modulo arithmetic; the final unsigned result never overflows.
REQ-011 out_valid SHALL be 1 only in DONE, and out_p SHALL hold the final accumulator value there.
REQ-012 out_p SHALL stay stable while out_valid=1 and out_ready=0.
REQ-013 In DONE with out_ready=1, the next state SHALL be IDLE; in_ready is not asserted in DONE, so no overlap occurs.
REQ-014 Latency SHALL be 5 cycles: out_valid rises on the 5th rising edge after the accept edge; peak throughput is one product per 6 cycles.
REQ-015 in_valid, in_a and in_b SHALL be ignored outside IDLE; changing them mid-operation has no effect.
REQ-016 out_ready SHALL be ignored outside DONE.
REQ-017 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, in_ready=1 (IDLE value), out_valid=0, busy=0, out_p=0, accumulator=0, and operand registers=0.
REQ-019 A reset during P0..P3 or DONE SHALL abort the operation, and the pending product SHALL never be presented.
REQ-020 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-021 With macro MULT_SEQ_SIGNED_EN defined, the block SHALL add input port in_signed (1 bit), captured on accept.
REQ-022 With in_signed=1, operands SHALL be treated as two's complement: magnitudes are multiplied unsigned (magnitude of -32768 is 32768, held in 16 unsigned bits) and the 32-bit result is negated in DONE entry when the operand signs differ.
REQ-023 With in_signed=0, or with the macro undefined, operation SHALL be unsigned; with the macro undefined the in_signed port SHALL not exist.
REQ-024 Latency SHALL be 5 cycles in both builds.

Verification
REQ-025 Accept 0x1234*0x5678 -> out_valid on the 5th edge, out_p=0x06260060, busy=1 from the accept edge until the DONE handshake.
REQ-026 Accept 0xFFFF*0xFFFF -> out_p=0xFFFE0001; 0x0000*0xFFFF -> out_p=0x00000000.
REQ-027 Hold out_ready=0 for 3 cycles in DONE and toggle in_a/in_b/in_valid -> out_p stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-028 Drive rst_n low in P2 -> out_valid=0, busy=0 and in_ready=1 immediately; the next operation 3*5 -> 0x0000000F.
REQ-029 With MULT_SEQ_SIGNED_EN and in_signed=1: 0xFFFE*0x0003 -> 0xFFFFFFFA; 0x8000*0x8000 -> 0x40000000; with in_signed=0, 0xFFFE*0x0003 -> 0x0002FFFA.
REQ-030 Issue back-to-back accepts with in_valid held high and out_ready=1 -> accepts exactly 6 cycles apart, each product correct.
